// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - next-PC selector and PC register with trap entry/return.
// Optional PC_HISTORY_EN adds a 4-entry ring buffer of previous PC values.
module pc_next_unit #(
    parameter int                 WIDTH      = 32,
    parameter int                 NUM_SRC    = 5,
    parameter int                 SEL_W      = 3,
    parameter logic [WIDTH-1:0]   RESET_PC   = '0,
    parameter logic [WIDTH-1:0]   EXC_VECTOR = WIDTH'(32'h0000_00FC),
    parameter int                 ALIGN_BITS = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_SRC*WIDTH-1:0] i_src_flat,
    input  logic [SEL_W-1:0]         i_sel,
    input  logic                     i_pc_write,
    input  logic                     i_pc_write_cond,
    input  logic                     i_cond,
    input  logic                     i_exc_req,
    input  logic                     i_exc_ret,
    input  logic [1:0]               i_hist_idx,
    output logic [WIDTH-1:0]         o_pc,
    output logic [WIDTH-1:0]         o_epc,
    output logic                     o_in_trap,
    output logic                     o_pc_changed,
    output logic                     o_misalign,
    output logic                     o_sel_err,
    output logic                     o_double_fault,
    output logic [WIDTH-1:0]         o_hist_pc
);

    typedef enum logic {ST_RUN, ST_TRAP} state_t;

    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_pc, r_epc, w_pc_nxt, w_epc_nxt;
    logic             r_pc_changed, r_misalign, r_sel_err, r_double_fault;
    logic             w_chg_nxt, w_mis_nxt, w_sel_err_nxt, w_df_nxt;
    logic             w_wr, w_bad_sel, w_bad_al;
    logic [WIDTH-1:0] w_target;

    assign w_wr      = i_pc_write | (i_pc_write_cond & i_cond);
    assign w_bad_sel = (32'(i_sel) >= NUM_SRC);
    assign w_bad_al  = (w_target & ALIGN_MASK) != '0;

    // Out-of-range selects yield zero, which is always aligned, so bad_sel never masquerades as bad_al.
    always_comb begin
        w_target = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_sel == SEL_W'(i)) begin
                w_target = i_src_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_epc_nxt     = r_epc;
        w_chg_nxt     = 1'b0;
        w_mis_nxt     = 1'b0;
        w_sel_err_nxt = r_sel_err;
        w_df_nxt      = r_double_fault;
        case (r_state)
            ST_RUN: begin
                if (i_exc_req) begin
                    w_epc_nxt   = r_pc;
                    w_pc_nxt    = EXC_VECTOR;
                    w_state_nxt = ST_TRAP;
                    w_chg_nxt   = 1'b1;
                end else if (w_wr && w_bad_sel) begin
                    w_sel_err_nxt = 1'b1;
                end else if (w_wr && w_bad_al) begin
                    w_mis_nxt   = 1'b1;
                    w_epc_nxt   = r_pc;
                    w_pc_nxt    = EXC_VECTOR;
                    w_state_nxt = ST_TRAP;
                    w_chg_nxt   = 1'b1;
                end else if (w_wr) begin
                    w_pc_nxt  = w_target;
                    w_chg_nxt = 1'b1;
                end
            end
            ST_TRAP: begin
                // A fault inside the handler cannot be nested: flag it and keep the saved EPC.
                if (i_exc_req || (w_wr && w_bad_al)) begin
                    w_df_nxt  = 1'b1;
                    w_mis_nxt = w_wr && w_bad_al;
                end else if (i_exc_ret) begin
                    w_pc_nxt    = r_epc;
                    w_state_nxt = ST_RUN;
                    w_chg_nxt   = 1'b1;
                end else if (w_wr && w_bad_sel) begin
                    w_sel_err_nxt = 1'b1;
                end else if (w_wr) begin
                    w_pc_nxt  = w_target;
                    w_chg_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_RUN;
            r_pc           <= RESET_PC;
            r_epc          <= '0;
            r_pc_changed   <= 1'b0;
            r_misalign     <= 1'b0;
            r_sel_err      <= 1'b0;
            r_double_fault <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pc           <= w_pc_nxt;
            r_epc          <= w_epc_nxt;
            r_pc_changed   <= w_chg_nxt;
            r_misalign     <= w_mis_nxt;
            r_sel_err      <= w_sel_err_nxt;
            r_double_fault <= w_df_nxt;
        end
    end

    assign o_pc           = r_pc;
    assign o_epc          = r_epc;
    assign o_in_trap      = (r_state == ST_TRAP);
    assign o_pc_changed   = r_pc_changed;
    assign o_misalign     = r_misalign;
    assign o_sel_err      = r_sel_err;
    assign o_double_fault = r_double_fault;

`ifdef PC_HISTORY_EN
    logic [WIDTH-1:0] r_hist [4];
    logic [1:0]       r_wptr;
    logic [1:0]       w_rd_idx;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 4; i++) begin
                r_hist[i] <= '0;
            end
            r_wptr <= 2'd0;
        end else if (w_chg_nxt) begin
            r_hist[r_wptr] <= r_pc;
            r_wptr         <= r_wptr + 2'd1;
        end
    end

    // r_wptr points at the next free slot, so the newest entry sits one behind it.
    assign w_rd_idx  = r_wptr - 2'd1 - i_hist_idx;
    assign o_hist_pc = r_hist[w_rd_idx];
`else
    logic [1:0] w_unused_idx;
    assign w_unused_idx = i_hist_idx;
    assign o_hist_pc    = '0;
`endif

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
Parametrised next-PC selector and PC register for the multicycle datapath.
- Selects one of NUM_SRC candidate addresses and loads it into the PC on an unconditional or conditional write.
- Checks select range and target alignment, and vectors to EXC_VECTOR on exception, capturing the EPC.
- Sits between the ALU/shift/sign-extend/EPC sources and the instruction-fetch address.

Parameters:
WIDTH, 32, address width in bits
NUM_SRC, 5, number of candidate sources (1..2**SEL_W)
SEL_W, 3, select width
RESET_PC, 32'h0000_0000, PC value after reset
EXC_VECTOR, 32'h0000_00FC, PC loaded on exception entry
ALIGN_BITS, 2, low target bits that must be zero (0 disables the check)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
src_flat  in  NUM_SRC*WIDTH  source i at [i*WIDTH +: WIDTH]
sel  in  SEL_W  source select
pc_write  in  1  unconditional PC write
pc_write_cond  in  1  conditional PC write (branch)
cond  in  1  branch condition (ALU zero)
exc_req  in  1  exception request
exc_ret  in  1  return from handler
pc  out  WIDTH  registered PC
epc  out  WIDTH  captured exception PC
in_trap  out  1  state == TRAP
pc_changed  out  1  one-cycle pulse: PC updated last edge
misalign  out  1  one-cycle pulse: misaligned target rejected
sel_err  out  1  sticky: write attempted with sel >= NUM_SRC
double_fault  out  1  sticky: exception while in TRAP

Behaviour:
- Clock and reset: all state updates on the rising edge of clk. reset is synchronous and active-high.
- Reset values: pc=RESET_PC, epc=0, state=RUN, pc_changed=0, misalign=0, sel_err=0, double_fault=0.
  - Reset overrides every other input in the same cycle.
  - Reset mid-trap returns to RUN.
- Derived signals:
  - wr = pc_write | (pc_write_cond & cond).
  - target = src_flat[sel*WIDTH +: WIDTH].
  - bad_sel = (sel >= NUM_SRC).
  - bad_al = ALIGN_BITS>0 && target[ALIGN_BITS-1:0] != 0.
- Latency: pc reflects an accepted write one cycle after the write cycle. No combinational path from inputs to pc.
- State RUN, priority order:
  1. exc_req: epc<=pc, pc<=EXC_VECTOR, go to TRAP, pc_changed=1.
  2. wr & bad_sel: sel_err<=1, pc holds, no exception.
  3. wr & bad_al: misalign=1, epc<=pc, pc<=EXC_VECTOR, go to TRAP, pc_changed=1.
  4. wr: pc<=target, pc_changed=1.
  5. Otherwise pc holds.
  - exc_ret in RUN is ignored.
- State TRAP (handler executing):
  1. exc_req, or wr & bad_al: double_fault<=1, pc holds, epc holds, stay in TRAP. misalign still pulses on a bad_al write.
  2. exc_ret: pc<=epc, go to RUN, pc_changed=1. Any write in the same cycle is ignored.
  3. wr & bad_sel: sel_err<=1, pc holds.
  4. wr: pc<=target, pc_changed=1.
- Sticky flag clearing: sel_err and double_fault clear only on reset.
- Pulse outputs: pc_changed and misalign are high for exactly one cycle per event.
- Arithmetic and select rules: no arithmetic on the PC inside the block (PC+4 arrives as a source). Selection is a full case with default = hold, so no latch and no stale output.
- Write with pc_write_cond=1 and cond=0 (pc_write=0): no change, no flags.

Optional Feature:
Macro PC_HISTORY_EN.
- Defined:
  - Adds a 4-entry ring buffer of previous PC values.
  - Each cycle with pc_changed about to assert pushes the old pc.
  - Input hist_idx (2 bits) selects hist_pc (WIDTH, combinational from the buffer). idx 0 = most recent.
  - Entries are 0 after reset. The buffer wraps, overwriting the oldest entry.
- Not defined: hist_idx is ignored and hist_pc is tied to 0. Ports remain present.

Test Plan:
- Reset release -> pc=0x0, all flags 0. Then pc_write=1, sel=1, src1=0x0000_0040 -> next cycle pc=0x40, pc_changed=1 for one cycle.
- Branch: pc_write_cond=1, cond=0, sel=2, src2=0x100 -> pc holds. Then cond=1 -> pc=0x100.
- Invalid select: pc_write=1, sel=6 (NUM_SRC=5) -> pc unchanged, sel_err=1 and stays 1 until reset.
- Misaligned: pc=0x40, pc_write=1, target=0x0000_0102 -> misalign pulse, epc=0x40, pc=0xFC, in_trap=1. Then exc_ret -> pc=0x40, in_trap=0.
- Nested exception: in TRAP with exc_req=1 and exc_ret=1 in the same cycle -> double_fault=1, pc and epc unchanged, in_trap stays 1.
- PC_HISTORY_EN: writes 0x10, 0x20, 0x30, 0x40, 0x50 from reset -> hist_idx 0..3 give 0x40, 0x30, 0x20, 0x10. Reset -> all entries 0.
